// File: rtl/alu_result_stage_pkg.sv
// Shared widths and packed types for the ALU result stage: flag word and buffered writeback entry.
package alu_result_stage_pkg;

  localparam int DATA_W = 12;
  localparam int DEST_W = 3;

  typedef struct packed {
    logic c;
    logic z;
    logic s;
    logic v;
  } flags_t;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [DEST_W-1:0] dest;
    logic              reg_we;
  } entry_t;

endpackage

// File: rtl/alu_result_stage_if.sv
// ALU-side and writeback-side handshake bundle; master is the environment, slave is the stage.
interface alu_result_stage_if;
  import alu_result_stage_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_result;
  logic              in_carry;
  logic              in_equ;
  logic              in_sign;
  logic              in_overflow;
  logic [DEST_W-1:0] in_dest;
  logic              in_reg_we;
  logic              in_flag_we;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic [DEST_W-1:0] out_dest;
  logic              out_reg_we;

  modport master (
    output in_valid, in_result, in_carry, in_equ, in_sign, in_overflow,
    output in_dest, in_reg_we, in_flag_we, out_ready,
    input  in_ready, out_valid, out_result, out_dest, out_reg_we
  );

  modport slave (
    input  in_valid, in_result, in_carry, in_equ, in_sign, in_overflow,
    input  in_dest, in_reg_we, in_flag_we, out_ready,
    output in_ready, out_valid, out_result, out_dest, out_reg_we
  );

endinterface

// File: rtl/alu_skid_buffer.sv
// Valid/ready buffer, 1 cycle latency; ALU_RESULT_SKID_EN gives 2 entries with registered in_ready,
// otherwise a single register whose in_ready passes out_ready combinationally.
module alu_skid_buffer
  import alu_result_stage_pkg::*;
#(
  parameter type T = entry_t
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid_i,
  output logic in_ready_o,
  input  T     in_data_i,
  output logic out_valid_o,
  input  logic out_ready_i,
  output T     out_data_o
);

  logic init_q;
  logic main_vld_q, main_vld_d;
  T     main_q, main_d;
  logic accept;
  logic xfer;

  assign accept      = in_valid_i & in_ready_o;
  assign xfer        = main_vld_q & out_ready_i;
  assign out_valid_o = main_vld_q;
  assign out_data_o  = main_q;

  // Held low through reset and for the release cycle so upstream never fires into a resetting stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) init_q <= 1'b0;
    else     init_q <= 1'b1;
  end

`ifdef ALU_RESULT_SKID_EN
  logic skid_vld_q, skid_vld_d;
  T     skid_q, skid_d;

  assign in_ready_o = init_q & ~skid_vld_q;

  always_comb begin
    main_d     = main_q;
    main_vld_d = main_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (skid_vld_q) begin
      // Skid is older than anything upstream; it refills main before new input is taken.
      if (xfer) begin
        main_d     = skid_q;
        skid_vld_d = 1'b0;
      end
    end else if (accept) begin
      if (!main_vld_q || xfer) begin
        main_d     = in_data_i;
        main_vld_d = 1'b1;
      end else begin
        skid_d     = in_data_i;
        skid_vld_d = 1'b1;
      end
    end else if (xfer) begin
      main_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
    end else begin
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
    end
  end
`else
  assign in_ready_o = init_q & (~main_vld_q | out_ready_i);

  always_comb begin
    main_d     = main_q;
    main_vld_d = main_vld_q;
    if (accept) begin
      main_d     = in_data_i;
      main_vld_d = 1'b1;
    end else if (xfer) begin
      main_vld_d = 1'b0;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q     <= '0;
      main_vld_q <= 1'b0;
    end else begin
      main_q     <= main_d;
      main_vld_q <= main_vld_d;
    end
  end

endmodule

// File: rtl/alu_result_stage.sv
// ALU result stage: buffers result/dest/reg_we to writeback (1 cycle when empty) and owns the flag register.
// Flags update on accept; ALU_RESULT_SKID_EN selects the 2-entry skid buffer with registered in_ready.
module alu_result_stage
  import alu_result_stage_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  alu_result_stage_if.slave   bus,
  input  logic                use_carry,
  input  logic                flag_clr,
  output logic                alu_carry_in,
  output logic                flag_c,
  output logic                flag_z,
  output logic                flag_s,
  output logic                flag_v
);

  flags_t flags_q, flags_d;
  entry_t in_entry;
  entry_t out_entry;
  logic   in_rdy;
  logic   out_vld;
  logic   accept;

  assign accept = bus.in_valid & in_rdy;

  always_comb begin
    in_entry        = '0;
    in_entry.result = bus.in_result;
    in_entry.dest   = bus.in_dest;
    in_entry.reg_we = bus.in_reg_we;
  end

  alu_skid_buffer #(.T(entry_t)) u_buf (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (bus.in_valid),
    .in_ready_o  (in_rdy),
    .in_data_i   (in_entry),
    .out_valid_o (out_vld),
    .out_ready_i (bus.out_ready),
    .out_data_o  (out_entry)
  );

  assign bus.in_ready   = in_rdy;
  assign bus.out_valid  = out_vld;
  assign bus.out_result = out_entry.result;
  assign bus.out_dest   = out_entry.dest;
  assign bus.out_reg_we = out_vld & out_entry.reg_we;

  // A flag-writing accept takes priority over a coincident clear.
  always_comb begin
    flags_d = flags_q;
    if (accept && bus.in_flag_we) begin
      flags_d.c = bus.in_carry;
      flags_d.z = bus.in_equ;
      flags_d.s = bus.in_sign;
      flags_d.v = bus.in_overflow;
    end else if (flag_clr) begin
      flags_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) flags_q <= '0;
    else     flags_q <= flags_d;
  end

  assign flag_c       = flags_q.c;
  assign flag_z       = flags_q.z;
  assign flag_s       = flags_q.s;
  assign flag_v       = flags_q.v;
  assign alu_carry_in = use_carry & flags_q.c;

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage: directed cases then random traffic against a queue/flag model.
module tb_alu_result_stage;
  import alu_result_stage_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic use_carry = 1'b0;
  logic flag_clr = 1'b0;
  logic alu_carry_in, flag_c, flag_z, flag_s, flag_v;

  alu_result_stage_if bus();

  alu_result_stage dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .use_carry    (use_carry),
    .flag_clr     (flag_clr),
    .alu_carry_in (alu_carry_in),
    .flag_c       (flag_c),
    .flag_z       (flag_z),
    .flag_s       (flag_s),
    .flag_v       (flag_v)
  );

  always #5 clk = ~clk;

  int     checks = 0;
  int     errors = 0;
  int     xfers  = 0;
  int     cyc    = 0;
  bit     started = 1'b0;
  bit     rnd_done;
  entry_t exp_q[$];
  logic [3:0] mflags = 4'h0;  // {c,z,s,v}

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    started = !rst;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge rst);
    exp_q.delete();
    mflags = 4'h0;
  end

  // Reference model: an accepted op joins the in-flight queue and may rewrite the flags.
  initial begin : model
    bit         acc, fwe, clr;
    logic [3:0] nf;
    entry_t     ne;
    forever begin
      @(negedge clk);
      acc = !rst && bus.in_valid && bus.in_ready;
      fwe = bus.in_flag_we;
      clr = flag_clr;
      nf  = {bus.in_carry, bus.in_equ, bus.in_sign, bus.in_overflow};
      ne.result = bus.in_result;
      ne.dest   = bus.in_dest;
      ne.reg_we = bus.in_reg_we;
      #1;
      if (!rst) begin
        if (acc) exp_q.push_back(ne);
        if (acc && fwe) mflags = nf;
        else if (clr)   mflags = 4'h0;
      end
    end
  end

  initial begin : monitor
    entry_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("out_valid", bus.out_valid, exp_q.size() > 0);
`ifdef ALU_RESULT_SKID_EN
        chk("in_ready", bus.in_ready, started && exp_q.size() < 2);
`else
        chk("in_ready", bus.in_ready, started && (exp_q.size() == 0 || bus.out_ready));
`endif
        chk("flags", {flag_c, flag_z, flag_s, flag_v}, mflags);
        chk("alu_carry_in", alu_carry_in, use_carry & mflags[3]);
        if (!bus.out_valid) begin
          chk("out_reg_we_idle", bus.out_reg_we, 0);
        end else if (bus.out_ready) begin
          xfers++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output actual=%0h required=none at %0t", bus.out_result, $time);
          end else begin
            e = exp_q.pop_front();
            chk("out_result", bus.out_result, e.result);
            chk("out_dest", bus.out_dest, e.dest);
            chk("out_reg_we", bus.out_reg_we, e.reg_we);
          end
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge with in_valid dropped.
  task automatic send(input logic [11:0] r, input logic [2:0] d, input logic [3:0] cesv,
                      input logic rwe, input logic fwe, input logic uc, input logic clr);
    int n = 0;
    bus.in_valid    = 1'b1;
    bus.in_result   = r;
    bus.in_dest     = d;
    {bus.in_carry, bus.in_equ, bus.in_sign, bus.in_overflow} = cesv;
    bus.in_reg_we   = rwe;
    bus.in_flag_we  = fwe;
    use_carry       = uc;
    flag_clr        = clr;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=stalled required=accept data=%0h", r);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    use_carry    = 1'b0;
    flag_clr     = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, x0;
    bus.in_valid = 0; bus.in_result = 0; bus.in_carry = 0; bus.in_equ = 0;
    bus.in_sign = 0; bus.in_overflow = 0; bus.in_dest = 0; bus.in_reg_we = 0;
    bus.in_flag_we = 0; bus.out_ready = 1;
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_result", bus.out_result, 0);
    chk("rst_out_dest", bus.out_dest, 0);
    chk("rst_out_reg_we", bus.out_reg_we, 0);
    chk("rst_flags", {flag_c, flag_z, flag_s, flag_v}, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    #1 chk("in_ready_before_edge", bus.in_ready, 0);
    @(posedge clk); #1;
    chk("in_ready_after_edge", bus.in_ready, 1);

    // Single ADD
    send(12'h7FF, 3'd3, 4'b0000, 1, 1, 0, 0);
    chk("add_out_valid", bus.out_valid, 1);
    chk("add_out_result", bus.out_result, 12'h7FF);
    chk("add_out_dest", bus.out_dest, 3);
    chk("add_flag_v", flag_v, 0);
    chk("add_flag_c", flag_c, 0);

    // Carry chain
    send(12'h001, 3'd1, 4'b1000, 1, 1, 0, 0);
    use_carry = 1'b1;
    #1 chk("carry_forward", alu_carry_in, 1);
    send(12'h002, 3'd2, 4'b0110, 1, 0, 1, 0);
    chk("carry_kept", flag_c, 1);

    // Flag clear vs flag-writing accept, then clear alone
    send(12'h000, 3'd4, 4'b0100, 0, 1, 0, 1);
    chk("clr_accept_wins", flag_z, 1);
    flag_clr = 1'b1;
    @(posedge clk); #1;
    flag_clr = 1'b0;
    chk("clr_alone", {flag_c, flag_z, flag_s, flag_v}, 0);

    // Backpressure: 3 results offered while writeback stalls 5 cycles
    repeat (3) @(posedge clk); #1;
    bus.out_ready = 1'b0;
    x0 = xfers;
    fork
      begin
        send(12'h001, 3'd1, 4'b0000, 1, 0, 0, 0);
        send(12'h002, 3'd2, 4'b0000, 1, 0, 0, 0);
        send(12'h003, 3'd3, 4'b0000, 1, 0, 0, 0);
      end
      begin
        repeat (5) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    repeat (6) @(posedge clk); #1;
    chk("bp_xfers", xfers - x0, 3);

    // Full-rate stream
    c0 = cyc;
    x0 = xfers;
    for (int i = 0; i < 16; i++) send(12'(i + 16), 3'(i), 4'b0000, 1, 0, 0, 0);
    chk("stream_cycles", cyc - c0, 16);
    repeat (3) @(posedge clk); #1;
    chk("stream_xfers", xfers - x0, 16);

    // Random traffic under random writeback stalls
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          send(12'($urandom_range(0, 4095)), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 7) == 0));
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    bus.out_ready = 1'b1;
    repeat (4) @(posedge clk); #1;
    chk("random_drained", exp_q.size(), 0);

    // Async reset mid-stall with entries held
    bus.out_ready = 1'b0;
    send(12'h0AA, 3'd5, 4'b1010, 1, 1, 0, 0);
    bus.in_valid  = 1'b1;
    bus.in_result = 12'h0BB;
    bus.in_dest   = 3'd6;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_out_valid", bus.out_valid, 0);
    chk("async_rst_flags", {flag_c, flag_z, flag_s, flag_v}, 0);
    chk("async_rst_out_reg_we", bus.out_reg_we, 0);
    bus.in_valid = 1'b0;
    #3 rst = 1'b0;
    #1 chk("rst_release_in_ready", bus.in_ready, 0);
    bus.out_ready = 1'b1;
    x0 = xfers;
    repeat (10) @(posedge clk); #1;
    chk("no_stale_outputs", xfers - x0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
